// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard: pipeline stage entry,
// forwarding select encodings and resolver hazard-input bit positions.
package hazard_pkg;

   // Register indices are stored zero-extended to this width so the stage
   // entry struct can live in the package independent of the top's RW.
   localparam int RW_MAX = 8;

   typedef logic [RW_MAX-1:0] reg_idx_t;

   typedef struct packed {
      logic     valid;
      reg_idx_t rd;
      logic     wr;
      logic     is_load;
   } stage_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam int POS_DATA = 7;
   localparam int POS_STR  = 6;
   localparam int POS_CTRL = 4;
   localparam int POS_FWRD = 3;
   localparam int POS_CRCT = 2;

   // True when an in-flight entry writes the register a used source reads.
   // Register 0 never matches when it is hardwired to zero.
   function automatic logic entry_match(stage_t e, reg_idx_t src,
                                        logic src_use, logic r0_zero);
      return src_use & e.valid & e.wr & (e.rd == src) &
             !(r0_zero & (src == '0));
   endfunction

   // Packs the individual hazard flags into the resolver's input vector.
   function automatic logic [7:0] resolver_vec(logic data, logic str,
                                               logic ctrl, logic fwrd,
                                               logic crct);
      logic [7:0] v;
      v           = '0;
      v[POS_DATA] = data;
      v[POS_STR]  = str;
      v[POS_CTRL] = ctrl;
      v[POS_FWRD] = fwrd;
      v[POS_CRCT] = crct;
      return v;
   endfunction

endpackage

// File: rtl/haz_src_match.sv
// Per-source dependency check against the EX and MEM entries. WB needs no
// check because the register file writes before it is read.
module haz_src_match
   import hazard_pkg::*;
#(
   parameter bit R0_ZERO = 1'b1
) (
   input  reg_idx_t   src,
   input  logic       src_use,
   input  stage_t     ex,
   input  stage_t     mem,
   output logic       hz,
   output logic       fwdable,
   output logic       ld_hit,
   output logic [1:0] sel
);

   logic ex_m;
   logic mem_m;

   assign ex_m  = entry_match(ex,  src, src_use, R0_ZERO);
   assign mem_m = entry_match(mem, src, src_use, R0_ZERO);

   // Youngest producer wins; a load still in EX has no result to forward yet.
   always_comb begin
      hz      = 1'b0;
      fwdable = 1'b0;
      ld_hit  = 1'b0;
      sel     = FWD_RF;
      if (ex_m) begin
         hz      = 1'b1;
         fwdable = !ex.is_load;
         ld_hit  = ex.is_load;
         sel     = ex.is_load ? FWD_RF : FWD_EX;
      end else if (mem_m) begin
         hz      = 1'b1;
         fwdable = 1'b1;
         sel     = FWD_MEM;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destination registers of instructions in EX/MEM/WB plus a pending
// branch flag and derives the hazard resolver's inputs for the ID instruction.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int RW      = 3,
   parameter bit R0_ZERO = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [RW-1:0]    id_rs1,
   input  logic [RW-1:0]    id_rs2,
   input  logic             id_rs1_use,
   input  logic             id_rs2_use,
   input  logic [RW-1:0]    id_rd,
   input  logic             id_wr,
   input  logic             id_is_load,
   input  logic             id_is_store,
   input  logic             id_is_branch,
   input  logic             stall_in,
   input  logic             flush_in,
   input  logic             br_resolved,
   input  logic             br_correct,
   output logic             haz_data,
   output logic             haz_fwrd,
   output logic             haz_str,
   output logic             haz_ctrl,
   output logic             haz_crct,
   output logic [1:0]       fwd_sel_rs1,
   output logic [1:0]       fwd_sel_rs2,
   output logic [CNT_W-1:0] stall_cnt
);

   stage_t ex_q;
   stage_t mem_q;
   stage_t wb_q;
   logic   br_pend;
   logic   crct_q;
   logic   enter;

   logic       hz1, hz2, fw1, fw2, ld1, ld2;
   logic [1:0] sel1, sel2;

   // A flush or stall turns the slot entering EX into a bubble.
   assign enter = id_valid & !stall_in & !flush_in;

   // Stage registers shift every cycle; reset drops every in-flight entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         if (enter) begin
            ex_q.valid   <= 1'b1;
            ex_q.rd      <= reg_idx_t'(id_rd);
            ex_q.wr      <= id_wr;
            ex_q.is_load <= id_is_load;
         end else begin
            ex_q <= '0;
         end
      end
   end

   // Branch tracking: a newly entering branch outranks a same-cycle resolve.
   always_ff @(posedge clk) begin
      if (rst) begin
         br_pend <= 1'b0;
         crct_q  <= 1'b0;
      end else begin
         br_pend <= (enter & id_is_branch) | (br_pend & !br_resolved);
         if (br_resolved) begin
            crct_q <= br_correct;
         end
      end
   end

   // Saturating count of frozen cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_in && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   haz_src_match #(.R0_ZERO(R0_ZERO)) u_rs1 (
      .src     (reg_idx_t'(id_rs1)),
      .src_use (id_rs1_use),
      .ex      (ex_q),
      .mem     (mem_q),
      .hz      (hz1),
      .fwdable (fw1),
      .ld_hit  (ld1),
      .sel     (sel1)
   );

   haz_src_match #(.R0_ZERO(R0_ZERO)) u_rs2 (
      .src     (reg_idx_t'(id_rs2)),
      .src_use (id_rs2_use),
      .ex      (ex_q),
      .mem     (mem_q),
      .hz      (hz2),
      .fwdable (fw2),
      .ld_hit  (ld2),
      .sel     (sel2)
   );

   // Hazard outputs are combinational from stage state and the ID fields.
   always_comb begin
      haz_data    = id_valid & (hz1 | hz2);
      haz_fwrd    = haz_data & (!hz1 | fw1) & (!hz2 | fw2);
      haz_str     = id_valid & id_is_store & ld2;
      haz_ctrl    = (id_valid & id_is_branch) | br_pend;
      haz_crct    = crct_q;
      fwd_sel_rs1 = id_valid ? sel1 : FWD_RF;
      fwd_sel_rs2 = id_valid ? sel2 : FWD_RF;
   end

   // The load flag of the rs1 check is covered by haz_fwrd; the WB entry is
   // kept only to model the full pipeline depth.
   logic unused_ok;
   assign unused_ok = ^{ld1, wb_q};

endmodule
